crd_phase_sequencer: RTL and testbench
======================================

// Module: crd_phase_sequencer
// PURPOSE
// Central scheduler for the CRD regression datapath: sequences sample LOAD into the 5 x-channel stores,
// 175 handshaked iterations of the Inverse core, then per-window phases XY_ACC -> ALFA -> SUM/RES for
// cfg_nwin windows. Emits all addresses/enables the datapath consumes; replaces its ad-hoc free-running counters.
// PARAMETERS
// NSAMP   175   samples per channel / per window
// NCH     5     x channels loaded sequentially
// NWIN_W  13    width of window count/index
// RD_LAT  1     store read latency; acc_en/acc_addr lag rd_addr by RD_LAT cycles (1..3)
// INV_TMO 1023  max cycles in INV_WAIT before ERR
// PORTS
// clk       in   1       clock
// rst       in   1       reset, asynchronous, active-low
// start     in   1       pulse; begins run (ignored unless IDLE/DONE/ERR)
// abort     in   1       sync; forces IDLE next cycle from any state
// cfg_nwin  in   NWIN_W  window count, sampled on accepted start
// in_valid  in   1       x sample present on datapath input this cycle
// inv_done  in   1       pulse from Inverse core: iteration complete
// ld_we/ld_ch/ld_addr out 1/3/8  store write strobe, channel 0..NCH-1, sample 0..NSAMP-1
// inv_start/inv_idx   out 1/8    1-cycle iteration kick, iteration index 0..NSAMP-1
// y_ready   out  1       XY_ACC issuing; upstream presents y
// rd_addr   out  8       store read address in XY_ACC
// acc_clr/acc_en/acc_addr out 1/1/8 accumulator clear (1 cycle on XY entry), accumulate, aligned address
// alfa_en   out  1       1-cycle alfa load
// sum_en/sum_addr, res_en/res_addr out 1/8 each  alfa*x product write; residual accumulate (sum delayed 1)
// win_done/win_idx out 1/NWIN_W  1-cycle pulse at window end, index of finished window
// busy/done/err    out 1 each    run active; run finished (held); inverse timeout (held)
// BEHAVIOUR
// - Reset: state IDLE; all outputs and counters 0.
// - IDLE: start -> LOAD; latch cfg_nwin; clear done/err; busy=1 in all states except IDLE/DONE/ERR.
// - LOAD: each in_valid cycle -> ld_we=1 with current (ld_ch,ld_addr); addr wraps NSAMP-1->0 and ch++.
//   No in_valid -> counters hold. After write (NCH-1,NSAMP-1) -> INV_ISSUE (exactly NCH*NSAMP writes).
// - INV_ISSUE: inv_start=1 one cycle, inv_idx=k -> INV_WAIT; tmo counter cleared.
// - INV_WAIT: inv_done -> k==NSAMP-1 ? (nwin==0 ? DONE : XY_ACC) : k++, INV_ISSUE.
//   inv_done in INV_ISSUE or outside INV_WAIT ignored. INV_TMO cycles without inv_done -> ERR.
// - XY_ACC: entry cycle acc_clr=1; rd_addr 0..NSAMP-1 on consecutive cycles with y_ready=1;
//   acc_en/acc_addr = y_ready/rd_addr delayed RD_LAT; state lasts NSAMP+RD_LAT cycles -> ALFA.
// - ALFA: alfa_en=1 one cycle -> SUM.
// - SUM: sum_en, sum_addr 0..NSAMP-1, then one drain cycle; res_en/res_addr = sum_en/sum_addr delayed 1.
//   NSAMP+1 cycles -> WIN_END.
// - WIN_END: win_done=1, win_idx=w; w==nwin-1 -> DONE else w++, XY_ACC.
// - Per-window latency = 2*NSAMP+RD_LAT+3 = 354 cycles (defaults), no gaps.
// - DONE/ERR: done or err held until start (new run) or abort (->IDLE, flags cleared).
// - abort beats start in the same cycle. All strobes deassert the cycle after abort takes effect.
// - Address/index counters saturate never: wrap only as specified; no strobe when counter would exceed range.
// - Async reset mid-run: immediate IDLE, strobes low; no partial-run state retained.
// TESTING
// - start, nwin=2, in_valid every cycle -> 875 ld_we, last (ch4,addr174); first inv_start next cycle.
// - inv_done 5 cycles after each inv_start -> 175 inv_start, inv_idx 0..174; then acc_clr 1 cycle.
// - in_valid 1-of-3 cycles in LOAD -> 875 writes, no duplicate/skipped (ch,addr); ld_we never without in_valid.
// - nwin=3 -> win_done at 354-cycle spacing, win_idx 0,1,2; done=1 after third; res_addr lags sum_addr by 1.
// - inv_done withheld on iteration 10 -> err=1 at 1023 cycles in INV_WAIT; busy=0; start restarts at LOAD.
// - abort during SUM of window 1 -> IDLE next cycle, all strobes 0; rst low mid-LOAD -> outputs 0 immediately.

Source files
------------

// File: rtl/crd_phase_sequencer.sv
// CRD regression datapath scheduler: LOAD, inverse iterations,
// then XY_ACC -> ALFA -> SUM/RES per window.
module crd_phase_sequencer #(
  parameter int NSAMP   = 175,
  parameter int NCH     = 5,
  parameter int NWIN_W  = 13,
  parameter int RD_LAT  = 1,
  parameter int INV_TMO = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [NWIN_W-1:0] cfg_nwin,
  input  logic              in_valid,
  input  logic              inv_done,
  output logic              ld_we,
  output logic [2:0]        ld_ch,
  output logic [7:0]        ld_addr,
  output logic              inv_start,
  output logic [7:0]        inv_idx,
  output logic              y_ready,
  output logic [7:0]        rd_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [7:0]        acc_addr,
  output logic              alfa_en,
  output logic              sum_en,
  output logic [7:0]        sum_addr,
  output logic              res_en,
  output logic [7:0]        res_addr,
  output logic              win_done,
  output logic [NWIN_W-1:0] win_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(INV_TMO + 1);
  localparam logic [7:0]    A_LAST   = 8'(NSAMP - 1);
  localparam logic [2:0]    CH_LAST  = 3'(NCH - 1);
  localparam logic [8:0]    XY_LAST  = 9'(NSAMP + RD_LAT - 1);
  localparam logic [8:0]    N9       = 9'(NSAMP);
  localparam logic [TW-1:0] TMO_LAST = TW'(INV_TMO - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_XY,
    S_ALFA, S_SUM, S_WEND, S_DONE, S_ERR
  } state_t;

  state_t state, state_n;
  logic [2:0]        ch, ch_n;
  logic [7:0]        addr, addr_n;
  logic [7:0]        k, k_n;
  logic [TW-1:0]     tmo, tmo_n;
  logic [8:0]        cnt, cnt_n;
  logic [NWIN_W-1:0] w, w_n;
  logic [NWIN_W-1:0] nwin, nwin_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      ch    <= '0;
      addr  <= '0;
      k     <= '0;
      tmo   <= '0;
      cnt   <= '0;
      w     <= '0;
      nwin  <= '0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      addr  <= addr_n;
      k     <= k_n;
      tmo   <= tmo_n;
      cnt   <= cnt_n;
      w     <= w_n;
      nwin  <= nwin_n;
    end
  end

  always_comb begin
    state_n = state;
    ch_n    = ch;
    addr_n  = addr;
    k_n     = k;
    tmo_n   = tmo;
    cnt_n   = cnt;
    w_n     = w;
    nwin_n  = nwin;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n = S_LOAD;
          nwin_n  = cfg_nwin;
          ch_n    = '0;
          addr_n  = '0;
          k_n     = '0;
          tmo_n   = '0;
          cnt_n   = '0;
          w_n     = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (addr == A_LAST) begin
            addr_n = '0;
            if (ch == CH_LAST) begin
              ch_n    = '0;
              state_n = S_ISSUE;
            end else begin
              ch_n = ch + 3'd1;
            end
          end else begin
            addr_n = addr + 8'd1;
          end
        end
      end
      S_ISSUE: begin
        tmo_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (inv_done) begin
          if (k == A_LAST) begin
            cnt_n   = '0;
            state_n = (nwin == '0) ? S_DONE : S_XY;
          end else begin
            k_n     = k + 8'd1;
            state_n = S_ISSUE;
          end
        end else if (tmo == TMO_LAST) begin
          state_n = S_ERR;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      S_XY: begin
        if (cnt == XY_LAST) begin
          cnt_n   = '0;
          state_n = S_ALFA;
        end else begin
          cnt_n = cnt + 9'd1;
        end
      end
      S_ALFA: begin
        cnt_n   = '0;
        state_n = S_SUM;
      end
      S_SUM: begin
        if (cnt == N9) begin
          cnt_n   = '0;
          state_n = S_WEND;
        end else begin
          cnt_n = cnt + 9'd1;
        end
      end
      S_WEND: begin
        if (w == nwin - NWIN_W'(1)) begin
          state_n = S_DONE;
        end else begin
          w_n     = w + NWIN_W'(1);
          cnt_n   = '0;
          state_n = S_XY;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // abort wins over everything, including a same-cycle start
    if (abort) state_n = S_IDLE;
  end

  assign ld_we     = (state == S_LOAD) && in_valid;
  assign ld_ch     = ch;
  assign ld_addr   = addr;
  assign inv_start = (state == S_ISSUE);
  assign inv_idx   = k;
  assign y_ready   = (state == S_XY) && (cnt < N9);
  assign rd_addr   = y_ready ? cnt[7:0] : '0;
  assign acc_clr   = (state == S_XY) && (cnt == '0);
  assign alfa_en   = (state == S_ALFA);
  assign sum_en    = (state == S_SUM) && (cnt < N9);
  assign sum_addr  = sum_en ? cnt[7:0] : '0;
  assign win_done  = (state == S_WEND);
  assign win_idx   = win_done ? w : '0;
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign busy      = !(state inside {S_IDLE, S_DONE, S_ERR});

  logic [RD_LAT-1:0] ye_d;
  logic [7:0]        ra_d [RD_LAT];

  // read-latency alignment for the accumulator and the 1-cycle residual lag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ye_d     <= '0;
      res_en   <= 1'b0;
      res_addr <= '0;
      for (int i = 0; i < RD_LAT; i++) ra_d[i] <= '0;
    end else if (abort) begin
      ye_d     <= '0;
      res_en   <= 1'b0;
      res_addr <= '0;
      for (int i = 0; i < RD_LAT; i++) ra_d[i] <= '0;
    end else begin
      ye_d[0]  <= y_ready;
      ra_d[0]  <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        ye_d[i] <= ye_d[i-1];
        ra_d[i] <= ra_d[i-1];
      end
      res_en   <= sum_en;
      res_addr <= sum_addr;
    end
  end

  assign acc_en   = ye_d[RD_LAT-1];
  assign acc_addr = ra_d[RD_LAT-1];

endmodule

// File: tb/tb_crd_phase_sequencer.sv
// Randomized bench for crd_phase_sequencer against a
// timeline model derived from the phase lengths.
module tb_crd_phase_sequencer;

  localparam int NSAMP   = 175;
  localparam int NCH     = 5;
  localparam int NWIN_W  = 13;
  localparam int RD_LAT  = 1;
  localparam int INV_TMO = 1023;
  localparam int P       = 2 * NSAMP + RD_LAT + 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NWIN_W-1:0] cfg_nwin = '0;
  logic              in_valid = 1'b0;
  logic              inv_done = 1'b0;
  logic              ld_we, inv_start, y_ready, acc_clr, acc_en;
  logic              alfa_en, sum_en, res_en, win_done;
  logic              busy, done, err;
  logic [2:0]        ld_ch;
  logic [7:0]        ld_addr, inv_idx, rd_addr, acc_addr;
  logic [7:0]        sum_addr, res_addr;
  logic [NWIN_W-1:0] win_idx;

  int n_vec = 0;
  int n_err = 0;

  crd_phase_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_nwin(cfg_nwin), .in_valid(in_valid), .inv_done(inv_done),
    .ld_we(ld_we), .ld_ch(ld_ch), .ld_addr(ld_addr),
    .inv_start(inv_start), .inv_idx(inv_idx),
    .y_ready(y_ready), .rd_addr(rd_addr),
    .acc_clr(acc_clr), .acc_en(acc_en), .acc_addr(acc_addr),
    .alfa_en(alfa_en), .sum_en(sum_en), .sum_addr(sum_addr),
    .res_en(res_en), .res_addr(res_addr),
    .win_done(win_done), .win_idx(win_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [75:0] all_outs;
  logic [11:0] strobes;
  assign all_outs = {ld_we, ld_ch, ld_addr, inv_start, inv_idx,
                     y_ready, rd_addr, acc_clr, acc_en, acc_addr,
                     alfa_en, sum_en, sum_addr, res_en, res_addr,
                     win_done, win_idx, busy, done, err};
  assign strobes = {ld_we, inv_start, y_ready, acc_clr, acc_en,
                    alfa_en, sum_en, res_en, win_done,
                    busy, done, err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    n_vec++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL reset_outs got %h exp 0", all_outs);
    end
    step();
    start = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_abort_beats_start();
    start = 1'b1;
    abort = 1'b1;
    cfg_nwin = 13'd4;
    step();
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (strobes !== '0) begin
      n_err++;
      $display("FAIL abort_start got %h exp 0", strobes);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_start(input int nw);
    start = 1'b1;
    cfg_nwin = nw[NWIN_W-1:0];
    step();
    start = 1'b0;
    cfg_nwin = NWIN_W'($urandom);
  endtask

  // mode 0: every cycle, 1: one in three, 2: random
  task automatic test_load(input int mode);
    int n = 0;
    int cyc = 0;
    bit v;
    while (n < NCH * NSAMP && cyc < 6000) begin
      v = (mode == 0) ? 1'b1 :
          (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      in_valid = v;
      start = (cyc == 100);
      inv_done = 1'($urandom);
      @(negedge clk);
      n_vec++;
      if (ld_we !== v || busy !== 1'b1 || inv_start !== 1'b0) begin
        n_err++;
        $display("FAIL load_we cyc %0d got we=%b busy=%b exp we=%b busy=1",
                 cyc, ld_we, busy, v);
      end
      if (v) begin
        n_vec++;
        if (ld_ch !== 3'(n / NSAMP) || ld_addr !== 8'(n % NSAMP)) begin
          n_err++;
          $display("FAIL load_addr n %0d got (%0d,%0d) exp (%0d,%0d)",
                   n, ld_ch, ld_addr, n / NSAMP, n % NSAMP);
        end
        n++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    inv_done = 1'b0;
    n_vec++;
    if (n != NCH * NSAMP) begin
      n_err++;
      $display("FAIL load_count got %0d exp %0d", n, NCH * NSAMP);
    end
  endtask

  // mode 0: inv_done 5 cycles after inv_start; 1: random gap + spurious
  task automatic test_inverse(input int mode, input int withhold);
    int d;
    for (int k = 0; k < NSAMP; k++) begin
      inv_done = (mode == 1) && ($urandom_range(0, 3) == 0);
      in_valid = 1'($urandom);
      @(negedge clk);
      n_vec++;
      if (inv_start !== 1'b1 || inv_idx !== 8'(k) ||
          ld_we !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL inv_issue k %0d got start=%b idx=%0d we=%b exp 1,%0d,0",
                 k, inv_start, inv_idx, ld_we, k);
      end
      step();
      if (k == withhold) begin
        inv_done = 1'b0;
        for (int j = 1; j <= INV_TMO; j++) begin
          @(negedge clk);
          n_vec++;
          if (err !== 1'b0 || busy !== 1'b1 || inv_start !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_wait j %0d got err=%b busy=%b exp 0,1",
                     j, err, busy);
          end
          step();
        end
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          n_vec++;
          if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
              inv_start !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_err got err=%b busy=%b done=%b exp 1,0,0",
                     err, busy, done);
          end
          step();
        end
        in_valid = 1'b0;
        return;
      end
      d = (mode == 1) ? $urandom_range(1, 8) : 5;
      for (int j = 1; j <= d; j++) begin
        inv_done = (j == d);
        in_valid = 1'($urandom);
        @(negedge clk);
        n_vec++;
        if (inv_start !== 1'b0 || busy !== 1'b1 || err !== 1'b0 ||
            ld_we !== 1'b0) begin
          n_err++;
          $display("FAIL inv_wait k %0d got start=%b busy=%b err=%b exp 0,1,0",
                   k, inv_start, busy, err);
        end
        step();
      end
    end
    inv_done = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_done_held();
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'($urandom);
      inv_done = 1'($urandom);
      @(negedge clk);
      n_vec++;
      if (strobes !== 12'b0000_0000_0010) begin
        n_err++;
        $display("FAIL done_held got %b exp 000000000010", strobes);
      end
      step();
    end
    in_valid = 1'b0;
    inv_done = 1'b0;
  endtask

  task automatic test_windows(input int nw, input int abort_t);
    int w, t, s;
    bit e_clr, e_yr, e_acc, e_alfa, e_sum, e_res, e_wd;
    logic [11:0] e_v, g_v;
    for (int ta = 0; ta < nw * P; ta++) begin
      w = ta / P;
      t = ta % P;
      s = t - (NSAMP + RD_LAT + 1);
      e_clr  = (t == 0);
      e_yr   = (t < NSAMP);
      e_acc  = (t >= RD_LAT) && (t < NSAMP + RD_LAT);
      e_alfa = (t == NSAMP + RD_LAT);
      e_sum  = (s >= 0) && (s < NSAMP);
      e_res  = (s >= 1) && (s <= NSAMP);
      e_wd   = (t == P - 1);
      abort = (ta == abort_t);
      in_valid = 1'($urandom);
      inv_done = 1'($urandom);
      @(negedge clk);
      e_v = {e_clr, e_yr, e_acc, e_alfa, e_sum, e_res, e_wd,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      g_v = {acc_clr, y_ready, acc_en, alfa_en, sum_en, res_en, win_done,
             busy, done, err, ld_we, inv_start};
      n_vec++;
      if (g_v !== e_v) begin
        n_err++;
        $display("FAIL win_strobes w %0d t %0d got %b exp %b", w, t, g_v, e_v);
      end
      if (e_yr && rd_addr !== 8'(t)) begin
        n_err++;
        $display("FAIL rd_addr t %0d got %0d exp %0d", t, rd_addr, t);
      end
      if (e_acc && acc_addr !== 8'(t - RD_LAT)) begin
        n_err++;
        $display("FAIL acc_addr t %0d got %0d exp %0d", t, acc_addr, t - RD_LAT);
      end
      if (e_sum && sum_addr !== 8'(s)) begin
        n_err++;
        $display("FAIL sum_addr t %0d got %0d exp %0d", t, sum_addr, s);
      end
      if (e_res && res_addr !== 8'(s - 1)) begin
        n_err++;
        $display("FAIL res_addr t %0d got %0d exp %0d", t, res_addr, s - 1);
      end
      if (e_wd && win_idx !== NWIN_W'(w)) begin
        n_err++;
        $display("FAIL win_idx got %0d exp %0d", win_idx, w);
      end
      step();
      if (ta == abort_t) begin
        abort = 1'b0;
        for (int j = 0; j < 4; j++) begin
          in_valid = 1'($urandom);
          inv_done = 1'($urandom);
          @(negedge clk);
          n_vec++;
          if (strobes !== '0) begin
            n_err++;
            $display("FAIL abort_strobes j %0d got %b exp 0", j, strobes);
          end
          step();
        end
        in_valid = 1'b0;
        inv_done = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    inv_done = 1'b0;
    test_done_held();
  endtask

  task automatic test_restart_after_err();
    do_start(1);
    in_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (err !== 1'b0 || busy !== 1'b1 || ld_we !== 1'b1 ||
        ld_ch !== 3'd0 || ld_addr !== 8'd0) begin
      n_err++;
      $display("FAIL err_restart got err=%b busy=%b we=%b ch=%0d a=%0d exp 0,1,1,0,0",
               err, busy, ld_we, ld_ch, ld_addr);
    end
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    n_vec++;
    if (strobes !== '0) begin
      n_err++;
      $display("FAIL err_abort got %b exp 0", strobes);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    do_start(2);
    in_valid = 1'b1;
    repeat (40) step();
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL async_rst got %h exp 0", all_outs);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL post_rst got %h exp 0", all_outs);
    end
    step();
    do_start(2);
    @(negedge clk);
    n_vec++;
    if (ld_we !== 1'b1 || ld_ch !== 3'd0 || ld_addr !== 8'd0) begin
      n_err++;
      $display("FAIL rst_restart got we=%b ch=%0d a=%0d exp 1,0,0",
               ld_we, ld_ch, ld_addr);
    end
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_abort_beats_start();

    do_start(2);
    test_load(0);
    test_inverse(0, -1);
    test_windows(2, -1);

    do_start(3);
    test_load(1);
    test_inverse(1, -1);
    test_windows(3, -1);

    do_start(0);
    test_load(2);
    test_inverse(1, -1);
    test_done_held();

    do_start(4);
    test_load(0);
    test_inverse(0, 10);
    test_restart_after_err();

    do_start(2);
    test_load(0);
    test_inverse(1, -1);
    test_windows(2, P + NSAMP + RD_LAT + 1 + 50);

    test_reset_mid_load();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
